// File: rtl/roll_accumulator.sv
// Purpose: sums all lanes of NUM/ROLL_NUM consecutive signed beats into one full-precision result.
// Latency: the result is registered on the edge that accepts the final beat and is visible the next cycle.
// Backpressure: only the final beat of a group stalls, while a result is held and data_out_ready is low.
module roll_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM        = 8,
    parameter int ROLL_NUM   = 2,
    parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(NUM)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic signed [ROLL_NUM-1:0][DATA_WIDTH-1:0] data_in,
    input  logic                                      data_in_valid,
    output logic                                      data_in_ready,
    output logic signed [OUT_WIDTH-1:0]                data_out,
    output logic                                      data_out_valid,
    input  logic                                      data_out_ready
);

    localparam int CYCLES = NUM / ROLL_NUM;
    // Keep the counter at least one bit wide so CYCLES==1 still elaborates.
    localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0]               r_beat;
    logic signed [OUT_WIDTH-1:0] r_acc;
    logic signed [OUT_WIDTH-1:0] r_data_out;
    logic                        r_data_out_valid;

    logic signed [OUT_WIDTH-1:0] w_partial;
    logic signed [OUT_WIDTH-1:0] w_sum;
    logic                        w_first;
    logic                        w_last;
    logic                        w_in_rdy;
    logic                        w_in_fire;
    logic                        w_out_fire;

    // Lane adder: each lane is sign-extended to the result width before summing.
    always_comb begin
        w_partial = '0;
        for (int i = 0; i < ROLL_NUM; i++) begin
            w_partial = w_partial + OUT_WIDTH'($signed(data_in[i]));
        end
    end

    // Handshake decode and the running sum including the current beat.
    always_comb begin
        w_first    = (r_beat == '0);
        w_last     = (r_beat == CW'(CYCLES - 1));
        w_sum      = w_first ? w_partial : (r_acc + w_partial);
        // Non-final beats never need the output register, so they are never stalled.
        w_in_rdy   = !w_last || !r_data_out_valid || data_out_ready;
        w_in_fire  = data_in_valid && w_in_rdy;
        w_out_fire = r_data_out_valid && data_out_ready;
    end

    // Beat counter and accumulator advance on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_acc  <= '0;
        end else if (w_in_fire) begin
            r_acc <= w_sum;
            if (w_last) begin
                r_beat <= '0;
            end else begin
                r_beat <= r_beat + CW'(1);
            end
        end
    end

    // Output register: a new result takes priority over draining, so a same-cycle
    // drain and final beat leaves valid high with the fresh sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
        end else if (w_in_fire && w_last) begin
            r_data_out       <= w_sum;
            r_data_out_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_data_out_valid <= 1'b0;
        end
    end

    assign data_in_ready  = w_in_rdy;
    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;

endmodule

// File: tb/tb_roll_accumulator.sv
// Bench for roll_accumulator with NUM=8, ROLL_NUM=2 (four beats per group).
// Expected sums are modelled from the driven lanes and queued; the monitor pops on each output handshake.
// Directed steps cover reset, basic/extreme sums, streaming, backpressure, mid-group reset and valid gaps.
module tb_roll_accumulator;

    localparam int DW  = 16;
    localparam int NUM = 8;
    localparam int RN  = 2;
    localparam int OW  = DW + $clog2(NUM);
    localparam int CYC = NUM / RN;

    logic                        clk = 1'b0;
    logic                        rst;
    logic signed [RN-1:0][DW-1:0] data_in;
    logic                        data_in_valid;
    logic                        data_in_ready;
    logic signed [OW-1:0]        data_out;
    logic                        data_out_valid;
    logic                        data_out_ready;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int pops   = 0;
    int pops0;
    longint m_acc = 0;
    int     m_cnt = 0;
    logic signed [OW-1:0] exp_q[$];

    logic                 prev_hold = 1'b0;
    logic signed [OW-1:0] prev_do;

    roll_accumulator #(
        .DATA_WIDTH(DW),
        .NUM(NUM),
        .ROLL_NUM(RN),
        .OUT_WIDTH(OW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted; the model updates on acceptance.
    task automatic beat(input int a, input int b);
        bit ok;
        ok = 1'b0;
        data_in[0]    = DW'(a);
        data_in[1]    = DW'(b);
        data_in_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (data_in_ready) begin
                ok = 1'b1;
                m_acc += longint'(a) + longint'(b);
                m_cnt++;
                if (m_cnt == CYC) begin
                    exp_q.push_back(OW'(m_acc));
                    m_acc = 0;
                    m_cnt = 0;
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        chk("beat_accepted", ok, 1);
    endtask

    // Idle cycles with garbage on the data lanes.
    task automatic idle(input int n);
        data_in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            data_in[0] = DW'($urandom);
            data_in[1] = DW'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: scoreboard on handshakes, stability while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hold) begin
                chk("hold_data", data_out, prev_do);
                chk("hold_valid", data_out_valid, 1);
            end
            if (data_out_valid && data_out_ready) begin
                if (exp_q.size() > 0) begin
                    chk("result", data_out, exp_q.pop_front());
                    pops++;
                end else begin
                    chk("unexpected_result", data_out_valid, 0);
                end
            end
        end
        prev_hold = data_out_valid && !data_out_ready && !rst;
        prev_do   = data_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_valid", data_out_valid, 0);
        chk("reset_data", data_out, 0);
        chk("reset_ready", data_in_ready, 1);

        // Basic group
        beat(1, 2); beat(3, 4); beat(5, 6); beat(7, 8);
        chk("basic_valid", data_out_valid, 1);
        chk("basic_sum", data_out, 36);
        idle(1);
        chk("basic_valid_drop", data_out_valid, 0);
        chk("basic_data_kept", data_out, 36);

        // Signed extremes
        for (int i = 0; i < CYC; i++) beat(-32768, -32768);
        chk("neg_sum", data_out, -262144);
        for (int i = 0; i < CYC; i++) beat(32767, 32767);
        chk("pos_sum", data_out, 262136);
        idle(1);

        // Back-to-back groups
        stalls = 0;
        pops0  = pops;
        for (int g = 0; g < 3; g++)
            for (int b = 0; b < CYC; b++)
                beat(g * 10 + b, -3 * b);
        idle(2);
        chk("b2b_stalls", stalls, 0);
        chk("b2b_results", pops - pops0, 3);

        // Backpressure
        data_out_ready = 1'b0;
        beat(1, 2); beat(3, 4); beat(5, 6); beat(7, 8);
        beat(2, 2); beat(2, 2); beat(2, 2);
        data_in[0]    = DW'(2);
        data_in[1]    = DW'(2);
        data_in_valid = 1'b1;
        @(negedge clk);
        chk("stall_ready", data_in_ready, 0);
        chk("stall_data", data_out, 36);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_ready2", data_in_ready, 0);
        chk("stall_valid", data_out_valid, 1);
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        beat(2, 2);
        chk("bp_new_valid", data_out_valid, 1);
        chk("bp_new_sum", data_out, 16);
        idle(2);

        // Reset mid-group
        beat(100, 100); beat(100, 100);
        data_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        exp_q.delete();
        chk("midrst_valid", data_out_valid, 0);
        chk("midrst_data", data_out, 0);
        chk("midrst_ready", data_in_ready, 1);
        for (int i = 0; i < CYC; i++) beat(1, 1);
        chk("midrst_sum", data_out, 8);
        idle(2);

        // Valid gaps with garbage lanes in between
        pops0 = pops;
        for (int g = 0; g < 4; g++)
            for (int b = 0; b < CYC; b++) begin
                beat(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
                idle(int'($urandom_range(0, 2)));
            end
        idle(3);
        chk("gap_results", pops - pops0, 4);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/roll_accumulator.md
# roll_accumulator

Downstream consumer of the conv roller stage. Accepts a stream of ROLL_NUM-wide signed beats and sums all lanes of NUM/ROLL_NUM consecutive beats. Each completed group yields one full-precision result through a valid/ready output register. Sustains one beat per cycle with no bubble between groups when the output is drained.

## Interface
Parameters:
- DATA_WIDTH, 16, width of each signed input lane
- NUM, 8, total elements per group; must be a multiple of ROLL_NUM
- ROLL_NUM, 2, lanes per input beat
- OUT_WIDTH, DATA_WIDTH + $clog2(NUM), result width; must be ≥ that default so the sum cannot overflow

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- data_in  in  DATA_WIDTH × [ROLL_NUM-1:0]  signed lanes of one beat
- data_in_valid  in  1  beat present
- data_in_ready  out  1  beat accepted when valid && ready
- data_out  out  OUT_WIDTH  signed group sum
- data_out_valid  out  1  result held in output register
- data_out_ready  in  1  consumer accepts result

## Operation
- CYCLES = NUM/ROLL_NUM beats per group. Beat counter `beat` runs 0..CYCLES-1.
- acc is OUT_WIDTH wide and signed.
- partial = sum of the ROLL_NUM lanes, each lane sign-extended to OUT_WIDTH. Lane order is irrelevant.
- On input handshake:
  - if beat==0: acc <= partial; otherwise acc <= acc + partial.
  - if beat==CYCLES-1: data_out <= acc + partial (or partial when CYCLES==1); data_out_valid <= 1; beat <= 0.
  - otherwise beat <= beat + 1.
- Non-final beats are accepted even while a result is pending. Only the final beat needs the output register.
- data_in_ready = (beat != CYCLES-1) || !data_out_valid || data_out_ready. This is combinational from data_out_ready.
- On output handshake with no final beat accepted in the same cycle: data_out_valid <= 0. data_out keeps its last value.
- Output handshake and final-beat acceptance in the same cycle: the new result replaces the old one and data_out_valid stays 1.
- No handshake: all state holds.
- data_in is ignored when data_in_valid=0.
- Reset values:
  - beat = 0, acc = 0.
  - data_out = 0, data_out_valid = 0.
  - data_in_ready = 1 combinationally after reset.
- Reset mid-group discards the partial accumulation and any pending result. The next accepted beat starts a new group.

## Timing
- Latency: data_out_valid rises on the clock edge that accepts the final beat. It is visible the following cycle.
- Throughput: one beat per cycle. One result per CYCLES cycles with data_out_ready held high.
- Back-to-back groups: the first beat of group N+1 is accepted the cycle after the final beat of group N, with no bubble.
- Stall: data_in_ready drops only when beat==CYCLES-1, data_out_valid=1 and data_out_ready=0.
- data_out and data_out_valid must stay stable while valid && !ready.
- CYCLES==1: every beat is final. Behaviour reduces to a registered lane adder with a one-entry output buffer.

## Test plan
- Basic group (NUM=8, ROLL_NUM=2), data_out_ready=1: beats (1,2),(3,4),(5,6),(7,8) on consecutive cycles → data_out=36, valid for 1 cycle, visible the cycle after beat 4.
- Signed extremes: all 8 lanes = -32768 → data_out = -262144 (19-bit, no overflow). All lanes = 32767 → 262136.
- Back-to-back: 3 groups streamed continuously with ready=1 → data_in_ready never drops; results appear every 4 cycles with correct sums.
- Backpressure: data_out_ready=0 after group 1 (sum 36). Group 2 beats 1-3 are accepted and data_in_ready=0 at beat 4. Raise ready → 36 is consumed and beat 4 is accepted in the same cycle; group 2's sum appears next cycle.
- Reset mid-group: 2 beats (100,100),(100,100), then pulse rst → valid=0, data_out=0. Next group (1,1)×4 → 8, with no contamination from the earlier beats.
- Idle/valid gaps: random valid deasserts inside a group, and data_in toggled while valid=0 → sums are unaffected.
